// File: rtl/amm_pipe_bridge.sv
// ---------------------------------------------------------------------------
// amm_pipe_bridge
//   Pipelining bridge between the memory checker's Avalon-MM master (s_*)
//   and the memory controller (m_*).
//   - The command path is registered through a MAIN/SKID pair, so
//     s_waitrequest_o never depends combinationally on m_waitrequest_i.
//   - Outstanding read words are capped at MAX_PEND, so the readdata path
//     can never be overrun.
//   - Read data is returned in arrival order.
//
// Optional feature macro: AMM_BRIDGE_RSP_REG_EN
//   defined   : s_readdatavalid_o/s_readdata_o are registered (1 cycle latency)
//   undefined : combinational pass-through from m_readdatavalid_i/m_readdata_i
//
// Ports
//   clk_i, rst_i            clock, synchronous active-low reset
//   s_* (command inputs)    address, read, write, writedata, burstcount, byteenable
//   s_waitrequest_o         slave stall (skid full or read credit exhausted)
//   s_readdatavalid_o/_data read response towards the checker
//   m_* (command outputs)   registered copy of the accepted command stream
//   m_waitrequest_i         memory stall
//   m_readdatavalid_i/_data read response from the memory controller
// ---------------------------------------------------------------------------

package rtl_settings_pkg;

  localparam int unsigned AMM_ADDR_W  = 24;
  localparam int unsigned AMM_DATA_W  = 32;
  localparam int unsigned AMM_BURST_W = 4;
  localparam int unsigned DATA_B_W    = AMM_DATA_W / 8;

  // One Avalon-MM command beat as held in the MAIN and SKID registers.
  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [AMM_ADDR_W-1:0]  addr;
    logic [AMM_DATA_W-1:0]  wdata;
    logic [AMM_BURST_W-1:0] burst;
    logic [DATA_B_W-1:0]    be;
  } amm_cmd_t;

endpackage

module amm_pipe_bridge
  import rtl_settings_pkg::*;
#(
  parameter int unsigned MAX_PEND = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // slave side (from the memory checker)
  input  logic [AMM_ADDR_W-1:0]  s_address_i,
  input  logic                   s_read_i,
  input  logic                   s_write_i,
  input  logic [AMM_DATA_W-1:0]  s_writedata_i,
  input  logic [AMM_BURST_W-1:0] s_burstcount_i,
  input  logic [DATA_B_W-1:0]    s_byteenable_i,
  output logic                   s_waitrequest_o,
  output logic                   s_readdatavalid_o,
  output logic [AMM_DATA_W-1:0]  s_readdata_o,
  // master side (to the memory controller)
  output logic [AMM_ADDR_W-1:0]  m_address_o,
  output logic                   m_read_o,
  output logic                   m_write_o,
  output logic [AMM_DATA_W-1:0]  m_writedata_o,
  output logic [AMM_BURST_W-1:0] m_burstcount_o,
  output logic [DATA_B_W-1:0]    m_byteenable_o,
  input  logic                   m_waitrequest_i,
  input  logic                   m_readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]  m_readdata_i
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
  // One extra bit so pend + burstcount cannot wrap before the compare.
  localparam int unsigned SUM_W  = PEND_W + 1;

  amm_cmd_t            main_q, main_d;
  amm_cmd_t            skid_q, skid_d;
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PEND_W-1:0]   pend_q, pend_d;

  amm_cmd_t            in_cmd;
  logic                beat;
  logic                accept;
  logic                main_free;
  logic                rd_block;
  logic                rsp_valid;
  logic [SUM_W-1:0]    pend_sum;
  logic [SUM_W-1:0]    pend_inc;
  logic [SUM_W-1:0]    pend_dec;

`ifdef AMM_BRIDGE_RSP_REG_EN
  logic                  rsp_valid_q, rsp_valid_d;
  logic [AMM_DATA_W-1:0] rsp_data_q,  rsp_data_d;
`endif

  // Response path: registered or pass-through; rsp_valid drives the credit return.
`ifdef AMM_BRIDGE_RSP_REG_EN
  always_comb begin
    rsp_valid_d = m_readdatavalid_i;
    rsp_data_d  = rsp_data_q;
    if (m_readdatavalid_i) begin
      rsp_data_d = m_readdata_i;
    end
  end

  assign s_readdatavalid_o = rsp_valid_q;
  assign s_readdata_o      = rsp_data_q;
`else
  assign s_readdatavalid_o = m_readdatavalid_i;
  assign s_readdata_o      = m_readdata_i;
`endif

  assign rsp_valid = s_readdatavalid_o;

  // Master command outputs come straight from the MAIN register.
  assign m_read_o       = main_valid_q & main_q.rd;
  assign m_write_o      = main_valid_q & main_q.wr;
  assign m_address_o    = main_q.addr;
  assign m_writedata_o  = main_q.wdata;
  assign m_burstcount_o = main_q.burst;
  assign m_byteenable_o = main_q.be;

  // Handshake, read-credit check and MAIN/SKID next state.
  always_comb begin
    in_cmd       = '{rd:    s_read_i,
                     wr:    s_write_i,
                     addr:  s_address_i,
                     wdata: s_writedata_i,
                     burst: s_burstcount_i,
                     be:    s_byteenable_i};
    beat         = s_read_i | s_write_i;
    pend_sum     = SUM_W'(pend_q) + SUM_W'(s_burstcount_i);
    rd_block     = s_read_i & (pend_sum > SUM_W'(MAX_PEND));
    // skid_valid_q is a flop, so only the read-credit term is combinational.
    s_waitrequest_o = skid_valid_q | rd_block;
    accept       = beat & ~s_waitrequest_o;
    main_free    = ~main_valid_q | ~m_waitrequest_i;

    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    // Drain: SKID always refills MAIN first to keep strict order.
    if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // Fill: accept implies SKID was empty, so SKID is never overwritten.
    if (accept) begin
      if (main_free && !skid_valid_q) begin
        main_d       = in_cmd;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_cmd;
        skid_valid_d = 1'b1;
      end
    end

    // Read credit: add on accepted read, return one per delivered word,
    // ignore returns at zero (stale words after a reset).
    pend_inc = (accept & s_read_i) ? SUM_W'(s_burstcount_i) : '0;
    pend_dec = (rsp_valid && (pend_q != '0)) ? SUM_W'(1) : '0;
    pend_d   = PEND_W'(SUM_W'(pend_q) + pend_inc - pend_dec);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      pend_q       <= '0;
`ifdef AMM_BRIDGE_RSP_REG_EN
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
`endif
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      pend_q       <= pend_d;
`ifdef AMM_BRIDGE_RSP_REG_EN
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
`endif
    end
  end

  // A zero-length burst is an illegal command from the checker.
  a_burst_nonzero: assert property (@(posedge clk_i) disable iff (!rst_i)
    (s_read_i | s_write_i) |-> (s_burstcount_i != '0));

  a_pend_bound: assert property (@(posedge clk_i) disable iff (!rst_i)
    pend_q <= PEND_W'(MAX_PEND));

endmodule

// File: tb/tb_amm_pipe_bridge.sv
// ---------------------------------------------------------------------------
// tb_amm_pipe_bridge
//   Self-checking bench for amm_pipe_bridge with MAX_PEND = 16.
//   Reference model: command FIFO of accepted beats (occupancy <= 2),
//   integer read-credit counter, and a memory FIFO of words owed.
// ---------------------------------------------------------------------------

module tb_amm_pipe_bridge;
  import rtl_settings_pkg::*;

  localparam int unsigned MAX_PEND = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [AMM_ADDR_W-1:0]  s_address_i;
  logic                   s_read_i;
  logic                   s_write_i;
  logic [AMM_DATA_W-1:0]  s_writedata_i;
  logic [AMM_BURST_W-1:0] s_burstcount_i;
  logic [DATA_B_W-1:0]    s_byteenable_i;
  logic                   s_waitrequest_o;
  logic                   s_readdatavalid_o;
  logic [AMM_DATA_W-1:0]  s_readdata_o;
  logic [AMM_ADDR_W-1:0]  m_address_o;
  logic                   m_read_o;
  logic                   m_write_o;
  logic [AMM_DATA_W-1:0]  m_writedata_o;
  logic [AMM_BURST_W-1:0] m_burstcount_o;
  logic [DATA_B_W-1:0]    m_byteenable_o;
  logic                   m_waitrequest_i;
  logic                   m_readdatavalid_i;
  logic [AMM_DATA_W-1:0]  m_readdata_i;

  amm_pipe_bridge #(.MAX_PEND(MAX_PEND)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .s_address_i       (s_address_i),
    .s_read_i          (s_read_i),
    .s_write_i         (s_write_i),
    .s_writedata_i     (s_writedata_i),
    .s_burstcount_i    (s_burstcount_i),
    .s_byteenable_i    (s_byteenable_i),
    .s_waitrequest_o   (s_waitrequest_o),
    .s_readdatavalid_o (s_readdatavalid_o),
    .s_readdata_o      (s_readdata_o),
    .m_address_o       (m_address_o),
    .m_read_o          (m_read_o),
    .m_write_o         (m_write_o),
    .m_writedata_o     (m_writedata_o),
    .m_burstcount_o    (m_burstcount_o),
    .m_byteenable_o    (m_byteenable_o),
    .m_waitrequest_i   (m_waitrequest_i),
    .m_readdatavalid_i (m_readdatavalid_i),
    .m_readdata_i      (m_readdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic                   rd;
    logic                   wr;
    logic [AMM_ADDR_W-1:0]  addr;
    logic [AMM_DATA_W-1:0]  wdata;
    logic [AMM_BURST_W-1:0] burst;
    logic [DATA_B_W-1:0]    be;
  } tcmd_t;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  tcmd_t                 exp_q[$];   // beats accepted but not yet taken by memory
  logic [AMM_DATA_W-1:0] mem_q[$];   // words the memory still owes
  int                    pend_m;
  logic                  prev_rdv;
  logic [AMM_DATA_W-1:0] prev_rdd;

  // Stimulus controls.
  tcmd_t drv;
  int    mw_mode;      // 0 never stall, 1 random, 2 toggle 1010.., 3 stall count
  int    stall_left;
  bit    tog;
  int    rsp_pct;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit next_mwait();
    bit r;
    r = 1'b0;
    case (mw_mode)
      1: r = ($urandom_range(0, 99) < 35);
      2: begin tog = ~tog; r = tog; end
      3: if (stall_left > 0) begin stall_left--; r = 1'b1; end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, check at negedge+1, update model at posedge.
  task automatic cycle(output bit acc);
    bit                    mw, exp_wait, mval, mhs, exp_rdv;
    logic [AMM_DATA_W-1:0] exp_rdd;
    int                    pend_old;
    @(negedge clk_i);
    s_read_i       = drv.rd;
    s_write_i      = drv.wr;
    s_address_i    = drv.addr;
    s_writedata_i  = drv.wdata;
    s_burstcount_i = drv.burst;
    s_byteenable_i = drv.be;
    mw = next_mwait();
    m_waitrequest_i = mw;
    if (mem_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      m_readdatavalid_i = 1'b1;
      m_readdata_i      = mem_q.pop_front();
    end else begin
      m_readdatavalid_i = 1'b0;
      m_readdata_i      = $urandom;
    end
    #1;
    exp_wait = (exp_q.size() >= 2) ||
               (s_read_i && (pend_m + int'(s_burstcount_i) > int'(MAX_PEND)));
    check_eq("s_waitrequest", 64'(s_waitrequest_o), 64'(exp_wait));
    mval = (exp_q.size() > 0);
    check_eq("m_read",  64'(m_read_o),  64'(mval && exp_q[0].rd));
    check_eq("m_write", 64'(m_write_o), 64'(mval && exp_q[0].wr));
    if (mval) begin
      check_eq("m_address",    64'(m_address_o),    64'(exp_q[0].addr));
      check_eq("m_writedata",  64'(m_writedata_o),  64'(exp_q[0].wdata));
      check_eq("m_burstcount", 64'(m_burstcount_o), 64'(exp_q[0].burst));
      check_eq("m_byteenable", 64'(m_byteenable_o), 64'(exp_q[0].be));
    end
`ifdef AMM_BRIDGE_RSP_REG_EN
    exp_rdv = prev_rdv;
    exp_rdd = prev_rdd;
`else
    exp_rdv = m_readdatavalid_i;
    exp_rdd = m_readdata_i;
`endif
    check_eq("s_readdatavalid", 64'(s_readdatavalid_o), 64'(exp_rdv));
    if (exp_rdv) check_eq("s_readdata", 64'(s_readdata_o), 64'(exp_rdd));
    acc = (s_read_i || s_write_i) && !exp_wait;
    mhs = mval && !mw;
    @(posedge clk_i);
    pend_old = pend_m;
    if (mhs) begin
      if (exp_q[0].rd) begin
        for (int i = 0; i < int'(exp_q[0].burst); i++) mem_q.push_back($urandom);
      end
      void'(exp_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(drv);
      if (drv.rd) pend_m += int'(drv.burst);
    end
    if (exp_rdv && pend_old != 0) pend_m--;
    if (prev_rdv) prev_rdd = prev_rdd;
    prev_rdv = m_readdatavalid_i;
    if (m_readdatavalid_i) prev_rdd = m_readdata_i;
  endtask

  task automatic set_drv(input bit rd, input bit wr, input logic [AMM_ADDR_W-1:0] addr,
                         input logic [AMM_DATA_W-1:0] data, input int burst,
                         input logic [DATA_B_W-1:0] be);
    drv.rd    = rd;
    drv.wr    = wr;
    drv.addr  = addr;
    drv.wdata = data;
    drv.burst = AMM_BURST_W'(burst);
    drv.be    = be;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input bit rd, input logic [AMM_ADDR_W-1:0] addr,
                      input logic [AMM_DATA_W-1:0] data, input int burst,
                      input logic [DATA_B_W-1:0] be);
    bit acc;
    int n;
    set_drv(rd, !rd, addr, data, burst, be);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 400) begin
      cycle(acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n);
    bit acc;
    drv.rd = 1'b0;
    drv.wr = 1'b0;
    drv.burst = AMM_BURST_W'(1);
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_i);
    rst_i = 1'b0;
    drv.rd = 1'b0;
    drv.wr = 1'b0;
    s_read_i = 1'b0;
    s_write_i = 1'b0;
    m_readdatavalid_i = 1'b0;
    m_waitrequest_i = 1'b0;
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_m_read",      64'(m_read_o),          64'(0));
    check_eq("rst_m_write",     64'(m_write_o),         64'(0));
    check_eq("rst_s_wait",      64'(s_waitrequest_o),   64'(0));
    check_eq("rst_s_rdv",       64'(s_readdatavalid_o), 64'(0));
    check_eq("rst_m_address",   64'(m_address_o),       64'(0));
    check_eq("rst_m_writedata", 64'(m_writedata_o),     64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    mem_q.delete();
    pend_m   = 0;
    prev_rdv = 1'b0;
  endtask

  initial begin
    bit acc;
    int n;
    rst_i = 1'b0;
    s_read_i = 1'b0; s_write_i = 1'b0; s_address_i = '0; s_writedata_i = '0;
    s_burstcount_i = AMM_BURST_W'(1); s_byteenable_i = '1;
    m_waitrequest_i = 1'b0; m_readdatavalid_i = 1'b0; m_readdata_i = '0;
    prev_rdd = '0;
    mw_mode = 0; stall_left = 0; tog = 1'b0; rsp_pct = 100;
    set_drv(1'b0, 1'b0, '0, '0, 1, '1);
    do_reset(3);

    // Single write, memory never stalls.
    mw_mode = 0;
    send(1'b0, AMM_ADDR_W'(32'h10), AMM_DATA_W'(32'hA5A5_A5A5), 1, '1);
    idle(3);

    // Memory stalls 5 cycles while three writes arrive back to back.
    mw_mode = 3; stall_left = 5;
    send(1'b0, AMM_ADDR_W'(32'h20), AMM_DATA_W'(32'hD000_0000), 1, '1);
    send(1'b0, AMM_ADDR_W'(32'h21), AMM_DATA_W'(32'hD111_1111), 1, '1);
    send(1'b0, AMM_ADDR_W'(32'h22), AMM_DATA_W'(32'hD222_2222), 1, '1);
    mw_mode = 0;
    idle(4);

    // Write burst of 4 under a toggling waitrequest.
    mw_mode = 2; tog = 1'b0;
    for (int i = 0; i < 4; i++)
      send(1'b0, AMM_ADDR_W'(32'h40), AMM_DATA_W'(32'hCAFE_0000 + i), 4, 4'hF);
    mw_mode = 0;
    idle(4);

    // Reset mid write burst with SKID full, then two stale read words.
    mw_mode = 3; stall_left = 20;
    send(1'b0, AMM_ADDR_W'(32'h80), AMM_DATA_W'(32'h1111_0000), 4, '1);
    send(1'b0, AMM_ADDR_W'(32'h80), AMM_DATA_W'(32'h1111_0001), 4, '1);
    set_drv(1'b0, 1'b1, AMM_ADDR_W'(32'h80), AMM_DATA_W'(32'h1111_0002), 4, '1);
    cycle(acc);
    check_eq("t5_skid_full_stall", 64'(acc), 64'(0));
    mw_mode = 0; stall_left = 0;
    do_reset(1);
    mem_q.push_back(AMM_DATA_W'(32'h57A1_E000));
    mem_q.push_back(AMM_DATA_W'(32'h57A1_E001));
    rsp_pct = 100;
    idle(4);

    // Read credit: two bursts of 8 fill MAX_PEND=16, the third must wait for 8 words.
    rsp_pct = 0;
    send(1'b1, AMM_ADDR_W'(32'h100), '0, 8, '1);
    send(1'b1, AMM_ADDR_W'(32'h108), '0, 8, '1);
    set_drv(1'b1, 1'b0, AMM_ADDR_W'(32'h110), '0, 8, '1);
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      check_eq("t3_third_read_stalled", 64'(acc), 64'(0));
    end
    rsp_pct = 100;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      cycle(acc);
      n++;
    end
    check_eq("t3_third_read_accepted", 64'(acc), 64'(1));
    idle(30);

    // Read burst of 4 with immediate responses.
    send(1'b1, AMM_ADDR_W'(32'h200), '0, 4, '1);
    idle(10);

    // Randomized mixed traffic.
    mw_mode = 1; rsp_pct = 60;
    for (int t = 0; t < 250; t++) begin
      send($urandom_range(0, 1) == 1, AMM_ADDR_W'($urandom), AMM_DATA_W'($urandom),
           int'($urandom_range(1, 8)), DATA_B_W'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Drain everything still queued or owed.
    mw_mode = 0; rsp_pct = 100;
    n = 0;
    while ((exp_q.size() > 0 || mem_q.size() > 0) && n < 500) begin
      idle(1);
      n++;
    end
    check_eq("drain_done", 64'(exp_q.size() + mem_q.size()), 64'(0));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
